// File: rtl/range_scrub_pkg.sv
// Shared types and range helpers for range_scrub_regfile and its scrubber FSM.
// Index ranges may run ascending, descending or collapse to a single entry.
package range_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WB   = 2'd2
    } scrub_state_e;

    function automatic int range_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int range_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int range_depth(input int a, input int b);
        return range_max(a, b) - range_min(a, b) + 1;
    endfunction

    // 1 when the scrub pointer walks upward from the first index to the last
    function automatic bit range_ascending(input int from_idx, input int to_idx);
        return to_idx >= from_idx;
    endfunction

endpackage

// File: rtl/range_scrub_regfile_if.sv
// User-side bus of range_scrub_regfile: one write port, one registered read port, scrub status.
// Handshake: strobes are single-cycle; rd_valid/addr_err pulse for one cycle, one clock after the access.
interface range_scrub_regfile_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             addr_err;
    logic             scrub_busy;
    logic [AW-1:0]    scrub_idx;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, addr_err, scrub_busy, scrub_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, addr_err, scrub_busy, scrub_idx
    );
endinterface

// File: rtl/range_scrub_fsm.sv
// Scrubber sequencer: idle counter, IDLE/RD/WB state and the scrub pointer.
// Only instantiated when RANGE_SCRUB_SCRUBBER_EN is defined.
module range_scrub_fsm
    import range_scrub_pkg::*;
#(
    parameter int AW           = 4,
    parameter int IFROM        = 0,
    parameter int ITO          = 7,
    parameter int SCRUB_PERIOD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          user_wr_i,
    input  logic          user_same_i,
    output scrub_state_e  state_o,
    output logic [AW-1:0] idx_o,
    output logic          wb_write_o
);

    localparam bit              ASC       = range_ascending(IFROM, ITO);
    localparam int              CW        = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0]   IDX_FIRST = AW'(IFROM);
    localparam logic [AW-1:0]   IDX_LAST  = AW'(ITO);

    (* tmrg_triplicate *) scrub_state_e  state_q;
    (* tmrg_triplicate *) logic [CW-1:0] cnt_q;
    (* tmrg_triplicate *) logic [AW-1:0] idx_q;
    scrub_state_e  state_d;
    logic [CW-1:0] cnt_d;
    logic [AW-1:0] idx_d;
    logic [AW-1:0] idx_next;

    // Wrap from the last index back to the first; a one-entry range stays put.
    assign idx_next = (idx_q == IDX_LAST) ? IDX_FIRST
                    : (ASC ? idx_q + 1'b1 : idx_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wb_write_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD: state_d = WB;
            WB: begin
                // A user write elsewhere owns the write port; one to our index supersedes the buffer.
                if (!(user_wr_i && !user_same_i)) begin
                    wb_write_o = !user_same_i;
                    idx_d      = idx_next;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/range_scrub_regfile.sv
// Register array over an ascending/descending index range with a registered read port.
// Define RANGE_SCRUB_SCRUBBER_EN to add the background read/write-back scrubber.
module range_scrub_regfile
    import range_scrub_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int IFROM        = 0,
    parameter int ITO          = 7,
    parameter int AW           = 4,
    parameter int SCRUB_PERIOD = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    range_scrub_regfile_if.slave bus
);

    localparam int LO    = range_min(IFROM, ITO);
    localparam int DEPTH = range_depth(IFROM, ITO);

    (* tmrg_triplicate *) logic [WIDTH-1:0] mem_q [DEPTH];

    // Offsets below LO wrap to huge values, so one unsigned compare covers both bounds.
    logic [31:0] wr_off;
    logic [31:0] rd_off;
    logic        wr_ok;
    logic        rd_ok;
    assign wr_off = 32'(bus.wr_addr) - 32'(LO);
    assign rd_off = 32'(bus.rd_addr) - 32'(LO);
    assign wr_ok  = bus.wr_en && (wr_off < 32'(DEPTH));
    assign rd_ok  = bus.rd_en && (rd_off < 32'(DEPTH));

    logic [WIDTH-1:0] rd_word;
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_off == 32'(i)) rd_word = mem_q[i];
        end
    end

    logic             scrub_wb;
    logic [31:0]      scrub_off;
    logic [WIDTH-1:0] buf_q;

`ifdef RANGE_SCRUB_SCRUBBER_EN
    scrub_state_e     scrub_state;
    logic [AW-1:0]    scrub_idx;
    logic             user_same;
    logic [WIDTH-1:0] scrub_word;
    logic [WIDTH-1:0] buf_d;

    assign user_same = wr_ok && (bus.wr_addr == scrub_idx);

    range_scrub_fsm #(
        .AW          (AW),
        .IFROM       (IFROM),
        .ITO         (ITO),
        .SCRUB_PERIOD(SCRUB_PERIOD)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .user_wr_i  (wr_ok),
        .user_same_i(user_same),
        .state_o    (scrub_state),
        .idx_o      (scrub_idx),
        .wb_write_o (scrub_wb)
    );

    assign scrub_off = 32'(scrub_idx) - 32'(LO);

    always_comb begin
        scrub_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (scrub_off == 32'(i)) scrub_word = mem_q[i];
        end
    end

    // A user write landing on the entry being latched is forwarded, so write-back never restores stale data.
    always_comb begin
        buf_d = buf_q;
        if (scrub_state == RD) buf_d = user_same ? bus.wr_data : scrub_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buf_q <= '0;
        else        buf_q <= buf_d;
    end

    assign bus.scrub_busy = (scrub_state != IDLE);
    assign bus.scrub_idx  = scrub_idx;
`else
    assign scrub_wb       = 1'b0;
    assign scrub_off      = '0;
    assign buf_q          = '0;
    assign bus.scrub_busy = 1'b0;
    assign bus.scrub_idx  = AW'(IFROM);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_off == 32'(i)))               mem_q[i] <= bus.wr_data;
                else if (scrub_wb && (scrub_off == 32'(i)))    mem_q[i] <= buf_q;
            end
        end
    end

    // User-facing outputs stay single; the triplicated array is voted where it meets them.
    (* tmrg_do_not_triplicate *) logic [WIDTH-1:0] rd_data_q;
    (* tmrg_do_not_triplicate *) logic             rd_valid_q;
    (* tmrg_do_not_triplicate *) logic             addr_err_q;
    logic [WIDTH-1:0] rd_data_d;
    logic             rd_valid_d;
    logic             addr_err_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        addr_err_d = (bus.wr_en && !wr_ok) || (bus.rd_en && !rd_ok);
        if (bus.rd_en) rd_data_d = rd_ok ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_range_scrub_regfile.sv
// Bench for range_scrub_regfile over ranges [0:7], [7:0] and [7:7]; scrubber cases
// run when RANGE_SCRUB_SCRUBBER_EN is defined.
module tb_range_scrub_regfile;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  range_scrub_regfile_if #(.WIDTH(8), .AW(4)) if0 ();
  range_scrub_regfile_if #(.WIDTH(8), .AW(4)) if1 ();
  range_scrub_regfile_if #(.WIDTH(8), .AW(4)) if2 ();

  range_scrub_regfile #(.WIDTH(8), .IFROM(0), .ITO(7), .AW(4), .SCRUB_PERIOD(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  range_scrub_regfile #(.WIDTH(8), .IFROM(7), .ITO(0), .AW(4), .SCRUB_PERIOD(4))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  range_scrub_regfile #(.WIDTH(8), .IFROM(7), .ITO(7), .AW(4), .SCRUB_PERIOD(4))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic       wr_en   [3];
  logic [3:0] wr_addr [3];
  logic [7:0] wr_data [3];
  logic       rd_en   [3];
  logic [3:0] rd_addr [3];
  logic       rv_w    [3];
  logic       ae_w    [3];
  logic [7:0] rd_w    [3];
  logic       busy_w  [3];
  logic [3:0] sidx_w  [3];

  assign if0.wr_en = wr_en[0];  assign if0.wr_addr = wr_addr[0];  assign if0.wr_data = wr_data[0];
  assign if0.rd_en = rd_en[0];  assign if0.rd_addr = rd_addr[0];
  assign if1.wr_en = wr_en[1];  assign if1.wr_addr = wr_addr[1];  assign if1.wr_data = wr_data[1];
  assign if1.rd_en = rd_en[1];  assign if1.rd_addr = rd_addr[1];
  assign if2.wr_en = wr_en[2];  assign if2.wr_addr = wr_addr[2];  assign if2.wr_data = wr_data[2];
  assign if2.rd_en = rd_en[2];  assign if2.rd_addr = rd_addr[2];

  assign rv_w[0] = if0.rd_valid;  assign ae_w[0] = if0.addr_err;  assign rd_w[0] = if0.rd_data;
  assign rv_w[1] = if1.rd_valid;  assign ae_w[1] = if1.addr_err;  assign rd_w[1] = if1.rd_data;
  assign rv_w[2] = if2.rd_valid;  assign ae_w[2] = if2.addr_err;  assign rd_w[2] = if2.rd_data;
  assign busy_w[0] = if0.scrub_busy;  assign sidx_w[0] = if0.scrub_idx;
  assign busy_w[1] = if1.scrub_busy;  assign sidx_w[1] = if1.scrub_idx;
  assign busy_w[2] = if2.scrub_busy;  assign sidx_w[2] = if2.scrub_idx;

  int lo_t    [3] = '{0, 0, 7};
  int hi_t    [3] = '{7, 7, 7};
  int ifrom_t [3] = '{0, 7, 7};

  // Scoreboard entries are {rd_valid, addr_err, rd_data}
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];
  logic [7:0] model [3][16];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input int k, input logic [3:0] a);
    return (int'(a) >= lo_t[k]) && (int'(a) <= hi_t[k]);
  endfunction

  task automatic push(input int k, input logic [9:0] e);
    case (k)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // Called at a negedge; returns at the following negedge with strobes dropped.
  task automatic access(input int k, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input bit re, input logic [3:0] ra);
    bit wl, rl;
    logic [9:0] e;
    wl = legal(k, wa);
    rl = legal(k, ra);
    wr_en[k] = we;  wr_addr[k] = wa;  wr_data[k] = wd;
    rd_en[k] = re;  rd_addr[k] = ra;
    e = {re, (we && !wl) || (re && !rl), (re && rl) ? model[k][ra] : 8'h00};
    if (e[9] || e[8]) push(k, e);
    if (we && wl) model[k][wa] = wd;
    @(negedge clk);
    wr_en[k] = 1'b0;
    rd_en[k] = 1'b0;
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rd_data%0d", k), 32'(rd_w[k]), 32'h0);
      chk($sformatf("rst_rd_valid%0d", k), 32'(rv_w[k]), 32'h0);
      chk($sformatf("rst_addr_err%0d", k), 32'(ae_w[k]), 32'h0);
      chk($sformatf("rst_scrub_busy%0d", k), 32'(busy_w[k]), 32'h0);
      chk($sformatf("rst_scrub_idx%0d", k), 32'(sidx_w[k]), 32'(ifrom_t[k]));
    end
  endtask

  // Called at a negedge; asserts reset asynchronously partway into the low phase.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) model[k][a] = 8'h00;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef RANGE_SCRUB_SCRUBBER_EN
  // Returns at the negedge where scrubber k is first seen busy at idx (its RD cycle).
  task automatic wait_rd(input int k, input logic [3:0] idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 120 && !ok; c++) begin
      @(negedge clk);
      if (busy_w[k] && sidx_w[k] == idx) ok = 1'b1;
    end
  endtask
`endif

  logic [9:0] mon_e;
  bit         mon_have;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (rv_w[k] || ae_w[k]) begin
          mon_have = 1'b0;
          mon_e    = '0;
          case (k)
            0: if (exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_have = 1'b1; end
            1: if (exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_have = 1'b1; end
            default: if (exp_q2.size() > 0) begin mon_e = exp_q2.pop_front(); mon_have = 1'b1; end
          endcase
          n_cmp++;
          if (!mon_have) begin
            n_err++;
            $display("FAIL unexpected_out%0d: got v=%0b e=%0b d=%0h, expected no output",
                     k, rv_w[k], ae_w[k], rd_w[k]);
          end else if (rv_w[k] !== mon_e[9] || ae_w[k] !== mon_e[8] ||
                       (mon_e[9] && rd_w[k] !== mon_e[7:0])) begin
            n_err++;
            $display("FAIL read_resp%0d: got v=%0b e=%0b d=%0h, expected v=%0b e=%0b d=%0h",
                     k, rv_w[k], ae_w[k], rd_w[k], mon_e[9], mon_e[8], mon_e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int cur, nxt, steps, cyc, last_t, busy_cnt;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en[k] = 1'b0;  wr_addr[k] = '0;  wr_data[k] = '0;
      rd_en[k] = 1'b0;  rd_addr[k] = '0;
      for (int a = 0; a < 16; a++) model[k][a] = 8'h00;
    end
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending [0:7]
    access(0, 1, 4'd3, 8'hA5, 0, 4'd0);
    access(0, 0, 4'd0, 8'h00, 1, 4'd3);
    access(0, 1, 4'd0, 8'h5A, 0, 4'd0);
    access(0, 1, 4'd7, 8'hC3, 1, 4'd0);
    access(0, 1, 4'd4, 8'h77, 1, 4'd4);
    access(0, 0, 4'd0, 8'h00, 1, 4'd4);
    access(0, 0, 4'd0, 8'h00, 1, 4'd7);
    access(0, 1, 4'd8, 8'hEE, 0, 4'd0);
    access(0, 0, 4'd0, 8'h00, 1, 4'd9);
    access(0, 1, 4'd15, 8'hEE, 1, 4'd12);
    access(0, 1, 4'd2, 8'h22, 1, 4'd15);
    access(0, 0, 4'd0, 8'h00, 1, 4'd2);

    // Descending [7:0]
    access(1, 1, 4'd8, 8'h99, 0, 4'd0);
    access(1, 0, 4'd0, 8'h00, 1, 4'd8);
    access(1, 1, 4'd0, 8'h10, 0, 4'd0);
    access(1, 1, 4'd7, 8'h17, 1, 4'd0);
    access(1, 1, 4'd15, 8'h01, 1, 4'd7);
    access(1, 0, 4'd0, 8'h00, 1, 4'd0);

    // Single entry [7:7]
    access(2, 1, 4'd7, 8'h3C, 0, 4'd0);
    access(2, 0, 4'd0, 8'h00, 1, 4'd7);
    access(2, 1, 4'd6, 8'hFF, 1, 4'd7);
    access(2, 0, 4'd0, 8'h00, 1, 4'd0);
    access(2, 1, 4'd8, 8'hFF, 1, 4'd6);

`ifdef RANGE_SCRUB_SCRUBBER_EN
    for (int a = 0; a < 8; a++) access(1, 1, 4'(a), 8'(8'h30 + a), 0, 4'd0);
    cur = int'(sidx_w[1]);
    steps = 0;  cyc = 0;  last_t = -1;
    while (steps < 9 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (int'(sidx_w[1]) != cur) begin
        nxt = (cur == 0) ? 7 : cur - 1;
        chk("scrub_seq_desc", 32'(sidx_w[1]), 32'(nxt));
        if (last_t >= 0) chk("scrub_step_cycles", 32'(cyc - last_t), 32'd6);
        last_t = cyc;
        cur = int'(sidx_w[1]);
        steps++;
      end
    end
    chk("scrub_seq_steps", 32'(steps), 32'd9);
    for (int a = 0; a < 8; a++) access(1, 0, 4'd0, 8'h00, 1, 4'(a));

    busy_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk("scrub_idx_single", 32'(sidx_w[2]), 32'd7);
      if (busy_w[2]) busy_cnt++;
    end
    chk("scrub_busy_single", 32'(busy_cnt), 32'd6);

    // User write to the entry in write-back drops the write-back
    wait_rd(0, 4'd2, ok);
    chk("wait_rd_idx2", 32'(ok), 32'd1);
    @(negedge clk);
    chk("wb_busy", 32'(busy_w[0]), 32'd1);
    access(0, 1, 4'd2, 8'h11, 0, 4'd0);
    chk("wb_drop_idx", 32'(sidx_w[0]), 32'd3);
    chk("wb_drop_busy", 32'(busy_w[0]), 32'd0);
    access(0, 0, 4'd0, 8'h00, 1, 4'd2);

    // Writes elsewhere hold write-back until the port is free
    wait_rd(0, 4'd2, ok);
    chk("wait_rd_idx2b", 32'(ok), 32'd1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("wb_hold_busy", 32'(busy_w[0]), 32'd1);
      chk("wb_hold_idx", 32'(sidx_w[0]), 32'd2);
      access(0, 1, 4'd5, 8'(8'h50 + c), 0, 4'd0);
    end
    chk("wb_last_busy", 32'(busy_w[0]), 32'd1);
    chk("wb_last_idx", 32'(sidx_w[0]), 32'd2);
    @(negedge clk);
    chk("wb_done_busy", 32'(busy_w[0]), 32'd0);
    chk("wb_done_idx", 32'(sidx_w[0]), 32'd3);
    access(0, 0, 4'd0, 8'h00, 1, 4'd2);
    access(0, 0, 4'd0, 8'h00, 1, 4'd5);

    wait_rd(0, 4'd2, ok);
    chk("wait_rd_idx2c", 32'(ok), 32'd1);
    @(negedge clk);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("scrub_busy_off", 32'(busy_w[k]), 32'd0);
        chk("scrub_idx_off", 32'(sidx_w[k]), 32'(ifrom_t[k]));
      end
    end
`endif

    // Reset in the middle of activity, then every entry reads back zero
    do_reset();
    for (int a = 0; a < 8; a++) access(0, 0, 4'd0, 8'h00, 1, 4'(a));
    for (int a = 0; a < 8; a++) access(1, 0, 4'd0, 8'h00, 1, 4'(a));
    access(2, 0, 4'd0, 8'h00, 1, 4'd7);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
